uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame, sent LSB first.
REQ-002 The block SHALL have port clk, input, 1 bit: the receive clock, running at prescale × baud.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port rx_in, input, 1 bit: the serial line, idle high.
REQ-005 The block SHALL have port prescale, input, 6 bits: clk edges per bit; the legal values are 8, 16 and 32.
REQ-006 The block SHALL have port par_en, input, 1 bit: 1 means a parity bit follows the data.
REQ-007 The block SHALL have port par_typ, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 The block SHALL have port bit_count, input, 4 bits: the frame-bit index from the edge/bit counter.
REQ-009 The block SHALL have port edge_count, input, 6 bits: the edge index within the current bit, from the edge/bit counter.
REQ-010 The block SHALL have port count_en, output, 1 bit: the enable to the edge/bit counter; while it is low, the counter clears.
REQ-011 The block SHALL have port p_data, output, DATA_WIDTH bits: the last good received word.
REQ-012 The block SHALL have port data_valid, output, 1 bit: a 1-cycle pulse when p_data updates.
REQ-013 The block SHALL have ports par_err and stp_err, outputs, 1 bit each: 1-cycle error pulses at frame end.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; count_en SHALL be 1 in every state except IDLE, decoded from the state register.
REQ-015 In IDLE, when rx_in is 0 and prescale is 8, 16 or 32, the block SHALL go to START on the next clk and latch prescale, par_en and par_typ for the frame.
REQ-016 In IDLE, if rx_in is 0 and prescale is illegal, the block SHALL stay in IDLE with count_en 0.
REQ-017 The sampled bit value SHALL be final at edge_count equal to P/2+1, where P is the latched prescale.
REQ-018 The end of a bit SHALL be edge_count equal to P-1.
REQ-019 In START, at the end of the bit: if the sampled value is 1 (a glitch), the block SHALL go to IDLE with no error pulse; otherwise it SHALL go to DATA.
REQ-020 In DATA, the block SHALL write each sampled bit into a shift register at index bit_count-1, LSB first.
REQ-021 In DATA, at the end of bit_count equal to DATA_WIDTH, the block SHALL go to PARITY if the latched par_en is 1, else to STOP.
REQ-022 In PARITY, the block SHALL compare the sampled bit with XOR(data) XOR par_typ and hold the mismatch internally; at the end of the bit it SHALL go to STOP.
REQ-023 In STOP, a sampled stop value of 0 SHALL set the stop error; at edge P-1 the block SHALL go to IDLE.
REQ-024 On that same STOP exit cycle, the block SHALL either pulse data_valid with p_data updated (no error) or pulse par_err and/or stp_err (error).
REQ-025 On an error frame, p_data SHALL keep its previous value.
REQ-026 All outputs SHALL be registered, and data_valid SHALL never be high in the same cycle as par_err or stp_err.
REQ-027 A falling rx_in in the first IDLE cycle after STOP SHALL start a new frame, so back-to-back frames are accepted with no idle bit.
REQ-028 Changes to par_en, par_typ or prescale during a frame SHALL be ignored until the next IDLE.

Reset
REQ-029 While reset is 0, the block SHALL be in IDLE with count_en, data_valid, par_err and stp_err at 0, p_data all zeros, and the shift register and error flags cleared.
REQ-030 A reset asserted mid-frame SHALL discard the frame with no pulses.
REQ-031 The first frame after reset release SHALL be received normally.

Configuration
REQ-032 The macro RX_MAJORITY_SAMPLE_EN SHALL control the sampling method.
REQ-033 With RX_MAJORITY_SAMPLE_EN defined, the block SHALL capture rx_in at edge_count P/2-1, P/2 and P/2+1, and the bit value SHALL be the 2-of-3 majority.
REQ-034 Without RX_MAJORITY_SAMPLE_EN defined, the block SHALL take a single sample at edge_count P/2, and the P/2+1 decision point SHALL be unchanged.

Structure
REQ-035 The package uart_rx_pkg SHALL hold the state encoding, the legal prescale constants (8, 16, 32) and the sample-offset constants.
REQ-036 The bit sampling SHALL be in one sub-module, uart_rx_sampler (inputs clk, reset, rx_in, edge_count, P; output sampled_bit), holding the macro-dependent logic.

Verification
REQ-037 With P=16, par_en=0, the bench SHALL send frame 0xA5; the response SHALL be p_data=0xA5 with a 1-cycle data_valid at the end of the stop bit and no error pulses.
REQ-038 With P=8, par_en=1, par_typ=0, the bench SHALL send 0x3C with parity bit 1 (wrong); the response SHALL be one par_err pulse, no data_valid, and p_data unchanged.
REQ-039 With P=32, the bench SHALL send 0x81 with stop bit 0; the response SHALL be one stp_err pulse, then a return to IDLE.
REQ-040 The bench SHALL drive a 4-cycle low glitch on rx_in at P=16; the response SHALL be START, then IDLE, with no pulses and count_en low afterwards.
REQ-041 The bench SHALL assert reset during bit 4 of a frame; the response SHALL be all outputs 0, followed by a correct receive of a next frame of 0x5A.
REQ-042 With RX_MAJORITY_SAMPLE_EN defined, a 1-cycle inverted spike at edge P/2 SHALL give the correct bit; without the macro, the same stimulus SHALL give the flipped bit.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, legal prescale values and
// sample-point offsets for the UART receive controller.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   // early vote sits at P/2-1, the decision point at P/2+1
   localparam logic [5:0] SMP_EARLY_OFS = 6'd1;
   localparam logic [5:0] SMP_LATE_OFS  = 6'd1;

   function automatic logic prescale_ok(input logic [5:0] p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) ||
             (p == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit line sampling; RX_MAJORITY_SAMPLE_EN selects
// a 2-of-3 vote around mid-bit, otherwise a single mid-bit sample.
module uart_rx_sampler
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   input  logic [5:0] edge_count,
   input  logic [5:0] P,
   output logic       sampled_bit
);

   logic [5:0] mid;
   logic       s_mid;

   assign mid = P >> 1;

`ifdef RX_MAJORITY_SAMPLE_EN
   logic s_early;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_early <= 1'b1;
         s_mid   <= 1'b1;
      end else begin
         if (edge_count == mid - SMP_EARLY_OFS) s_early <= rx_in;
         if (edge_count == mid) s_mid <= rx_in;
      end
   end

   // third vote is the live line, captured by the caller at P/2+1
   assign sampled_bit = (s_early & s_mid) | (s_early & rx_in) |
                        (s_mid & rx_in);
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_mid <= 1'b1;
      end else if (edge_count == mid) begin
         s_mid <= rx_in;
      end
   end

   assign sampled_bit = s_mid;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive FSM driving an external edge/bit counter.
// Sampling method is selected by RX_MAJORITY_SAMPLE_EN (see sampler).
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_in,
   input  logic [5:0]            prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [3:0]            bit_count,
   input  logic [5:0]            edge_count,
   output logic                  count_en,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   state_t                state, nxt;
   logic [5:0]            p_q;
   logic                  par_en_q, par_typ_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  bit_q, par_flag;
   logic                  sampled_bit;
   logic                  bit_end, decide;
   logic                  frame_go, frame_done;

   uart_rx_sampler u_sampler (
      .clk         (clk),
      .reset       (reset),
      .rx_in       (rx_in),
      .edge_count  (edge_count),
      .P           (p_q),
      .sampled_bit (sampled_bit)
   );

   assign bit_end  = edge_count == p_q - 6'd1;
   assign decide   = edge_count == (p_q >> 1) + SMP_LATE_OFS;
   assign count_en = state != IDLE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt        = state;
      frame_go   = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (!rx_in && prescale_ok(prescale)) begin
               nxt      = START;
               frame_go = 1'b1;
            end
         end
         START: begin
            if (bit_end) nxt = bit_q ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end && bit_count == 4'(DATA_WIDTH))
               nxt = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) nxt = STOP;
         end
         STOP: begin
            if (bit_end) begin
               nxt        = IDLE;
               frame_done = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_q        <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         shift_q    <= '0;
         bit_q      <= 1'b0;
         par_flag   <= 1'b0;
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         if (frame_go) begin
            p_q       <= prescale;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_flag  <= 1'b0;
         end
         if (state != IDLE && decide) begin
            bit_q <= sampled_bit;
            if (state == DATA) begin
               for (int i = 0; i < DATA_WIDTH; i++)
                  if (bit_count == 4'(i + 1)) shift_q[i] <= sampled_bit;
            end
            if (state == PARITY)
               par_flag <= sampled_bit ^ (^shift_q) ^ par_typ_q;
         end
         // bit_q holds the stop-bit sample on the exit cycle
         if (frame_done) begin
            if (par_flag || !bit_q) begin
               par_err <= par_flag;
               stp_err <= !bit_q;
            end else begin
               data_valid <= 1'b1;
               p_data     <= shift_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frame table plus hand sequences for glitch,
// back-to-back, mid-frame reset, config change and sampling spike.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       line;
   logic       spike_on;
   int         spike_bit;
   int         cnt_p;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en, par_typ;
   logic [3:0] bit_count;
   logic [5:0] edge_count;
   logic       count_en;
   logic [7:0] p_data;
   logic       data_valid, par_err, stp_err;

   int total = 0;
   int bad   = 0;

   int n_dv = 0, n_pe = 0, n_se = 0, n_ovl = 0, n_long = 0, n_cen = 0;
   logic [7:0] last_dv = '0, prev_dv = '0;
   logic       pulse_d = 1'b0;

   typedef struct {
      logic [7:0] d;
      int         p;
      logic       pe;
      logic       pt;
      logic       pb;
      logic       sb;
      int         dv;
      int         perr;
      int         serr;
      logic [7:0] pd;
   } vec_t;

   vec_t tbl[9];

   always #5 clk = ~clk;

   assign rx_in = line ^ (spike_on && bit_count == 4'(spike_bit) &&
                          edge_count == 6'(cnt_p / 2));

   uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .bit_count  (bit_count),
      .edge_count (edge_count),
      .count_en   (count_en),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   // companion edge/bit counter
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         edge_count <= '0;
         bit_count  <= '0;
      end else if (!count_en) begin
         edge_count <= '0;
         bit_count  <= '0;
      end else if (edge_count == 6'(cnt_p - 1)) begin
         edge_count <= '0;
         bit_count  <= bit_count + 4'd1;
      end else begin
         edge_count <= edge_count + 6'd1;
      end
   end

   always @(negedge clk) begin
      if (data_valid) begin
         n_dv++;
         prev_dv = last_dv;
         last_dv = p_data;
      end
      if (par_err) n_pe++;
      if (stp_err) n_se++;
      if (data_valid && (par_err || stp_err)) n_ovl++;
      if (count_en) n_cen++;
      if (pulse_d && (data_valid || par_err || stp_err)) n_long++;
      pulse_d = data_valid || par_err || stp_err;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      line = b;
      repeat (cnt_p) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      line = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe,
                             input logic pb, input logic sb);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (pe) send_bit(pb);
      send_bit(sb);
   endtask

   initial begin
      int b_dv, b_pe, b_se, b_cen;
      logic [7:0] exp_spk;

      tbl[0] = '{8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
      tbl[1] = '{8'h3C,  8, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'hA5};
      tbl[2] = '{8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
      tbl[3] = '{8'h3C,  8, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
      tbl[4] = '{8'h7E, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'h7E};
      tbl[5] = '{8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h01};
      tbl[6] = '{8'h55, 16, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1, 8'h01};
      tbl[7] = '{8'h00, 12, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 8'h01};
      tbl[8] = '{8'hF0,  8, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 8'h01};

      reset     = 1'b0;
      line      = 1'b1;
      spike_on  = 1'b0;
      spike_bit = 0;
      cnt_p     = 16;
      prescale  = 6'd16;
      par_en    = 1'b0;
      par_typ   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count_en", count_en, 0);
      chk("rst_p_data", p_data, 0);
      chk("rst_pulses", {data_valid, par_err, stp_err}, 0);
      reset = 1'b1;
      idle(4);

      for (int k = 0; k < 9; k++) begin
         cnt_p    = tbl[k].p;
         prescale = 6'(tbl[k].p);
         par_en   = tbl[k].pe;
         par_typ  = tbl[k].pt;
         idle(4);
         b_dv = n_dv; b_pe = n_pe; b_se = n_se;
         send_frame(tbl[k].d, tbl[k].pe, tbl[k].pb, tbl[k].sb);
         idle(2 * tbl[k].p + 6);
         chk($sformatf("v%0d_dv", k), n_dv - b_dv, tbl[k].dv);
         chk($sformatf("v%0d_par_err", k), n_pe - b_pe, tbl[k].perr);
         chk($sformatf("v%0d_stp_err", k), n_se - b_se, tbl[k].serr);
         chk($sformatf("v%0d_p_data", k), p_data, tbl[k].pd);
         chk($sformatf("v%0d_idle", k), count_en, 0);
      end

      // glitch shorter than half a bit
      cnt_p = 16; prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
      idle(4);
      b_dv = n_dv; b_pe = n_pe; b_se = n_se; b_cen = n_cen;
      line = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(40);
      chk("glitch_start_cycles", n_cen - b_cen, 16);
      chk("glitch_count_en", count_en, 0);
      chk("glitch_pulses", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);

      // back-to-back frames with no idle bit between them
      b_dv = n_dv;
      send_frame(8'h12, 1'b0, 1'b0, 1'b1);
      send_frame(8'h34, 1'b0, 1'b0, 1'b1);
      idle(40);
      chk("b2b_dv", n_dv - b_dv, 2);
      chk("b2b_first", prev_dv, 8'h12);
      chk("b2b_second", last_dv, 8'h34);

      // config changes mid-frame must not take effect
      cnt_p = 8; prescale = 6'd8; par_en = 1'b0;
      idle(4);
      b_dv = n_dv; b_pe = n_pe;
      fork
         send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
         begin
            repeat (3) @(posedge clk);
            #1;
            prescale = 6'd16;
            par_en   = 1'b1;
            par_typ  = 1'b1;
         end
      join
      idle(30);
      chk("cfg_dv", n_dv - b_dv, 1);
      chk("cfg_par_err", n_pe - b_pe, 0);
      chk("cfg_p_data", p_data, 8'hC3);

      // reset during data bit 4
      cnt_p = 16; prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
      idle(4);
      b_dv = n_dv; b_pe = n_pe; b_se = n_se;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
      line = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_outputs", {count_en, data_valid, par_err, stp_err}, 0);
      chk("mid_rst_p_data", p_data, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      idle(4);
      chk("mid_rst_no_pulse", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      idle(40);
      chk("post_rst_dv", n_dv - b_dv, 1);
      chk("post_rst_p_data", p_data, 8'h5A);

      // one-cycle inverted spike exactly at mid-bit of data bit 2
`ifdef RX_MAJORITY_SAMPLE_EN
      exp_spk = 8'h00;
`else
      exp_spk = 8'h04;
`endif
      b_dv = n_dv;
      spike_bit = 3;
      spike_on  = 1'b1;
      send_frame(8'h00, 1'b0, 1'b0, 1'b1);
      idle(40);
      spike_on = 1'b0;
      chk("spike_dv", n_dv - b_dv, 1);
      chk("spike_p_data", p_data, exp_spk);

      chk("dv_err_overlap", n_ovl, 0);
      chk("pulse_width", n_long, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
